// File: rtl/vliw_fetch_buffer.sv
// Fetch-to-decode bundle FIFO for the VLIW pipeline, with decode stall and IF_Flush handling.
// Optional FETCH_STALL_CNT_EN adds a saturating stall_cnt output that counts decode stall cycles.
module vliw_fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    input  logic [PC_W-1:0]          fetch_pc,
    input  logic [47:0]              fetch_bundle,
    input  logic                     id_stall,
    input  logic                     IF_Flush,
    output logic                     id_valid,
    output logic [PC_W-1:0]          id_pc,
    output logic [31:0]              id_instr,
    output logic [15:0]              id_cinstr,
    output logic [6:0]               opcode,
    output logic [2:0]               funct_3,
    output logic [1:0]               opcode_c,
    output logic [2:0]               funct_3_c,
    output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic [15:0]     cinstr;
    } entry_t;

    entry_t            storage_q [DEPTH];
    entry_t            storage_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic   push;
    logic   pop;
    entry_t head;

    // Handshake depends only on registered occupancy, keeping id_stall off the fetch_ready path.
    always_comb begin
        fetch_ready = (count_q < DEPTH_CNT);
        id_valid    = (count_q != '0);
        push        = fetch_valid & fetch_ready;
        pop         = id_valid & ~id_stall;
    end

    always_comb begin
        storage_d = storage_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (IF_Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                storage_d[wr_ptr_q] = '{pc: fetch_pc,
                                        instr: fetch_bundle[47:16],
                                        cinstr: fetch_bundle[15:0]};
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            storage_q <= storage_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // An empty buffer presents all-zero fields so decode sees a harmless no-op.
    always_comb begin
        head      = id_valid ? storage_q[rd_ptr_q] : '0;
        id_pc     = head.pc;
        id_instr  = head.instr;
        id_cinstr = head.cinstr;
        opcode    = id_instr[6:0];
        funct_3   = id_instr[14:12];
        opcode_c  = id_cinstr[1:0];
        funct_3_c = id_cinstr[15:13];
        count     = count_q;
    end

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Survives IF_Flush so stall statistics span redirects; only rst clears it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (id_valid && id_stall && !IF_Flush && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vliw_fetch_buffer.sv
// Self-checking bench for vliw_fetch_buffer: queue-based reference model, directed scenarios and random traffic.
// Build with FETCH_STALL_CNT_EN defined to also exercise the stall counter.
module tb_vliw_fetch_buffer;

    localparam int DEPTH = 2;
    localparam int PC_W  = 32;

    logic                   clk;
    logic                   rst;
    logic                   fetch_valid;
    logic                   fetch_ready;
    logic [PC_W-1:0]        fetch_pc;
    logic [47:0]            fetch_bundle;
    logic                   id_stall;
    logic                   IF_Flush;
    logic                   id_valid;
    logic [PC_W-1:0]        id_pc;
    logic [31:0]            id_instr;
    logic [15:0]            id_cinstr;
    logic [6:0]             opcode;
    logic [2:0]             funct_3;
    logic [1:0]             opcode_c;
    logic [2:0]             funct_3_c;
    logic [$clog2(DEPTH):0] count;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0]            stall_cnt;
`endif

    vliw_fetch_buffer #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_pc     (fetch_pc),
        .fetch_bundle (fetch_bundle),
        .id_stall     (id_stall),
        .IF_Flush     (IF_Flush),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_instr     (id_instr),
        .id_cinstr    (id_cinstr),
        .opcode       (opcode),
        .funct_3      (funct_3),
        .opcode_c     (opcode_c),
        .funct_3_c    (funct_3_c),
        .count        (count)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the buffer is a plain FIFO of (pc, bundle) pairs.
    logic [PC_W-1:0] pcQ [$];
    logic [47:0]     bundleQ [$];
    int              modelStallCnt;

    int  checkCount;
    int  passCount;
    bit  checkEn;
    bit  pc200Seen;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelEdge();
        bit doPush;
        bit doPop;
        if (rst) begin
            pcQ.delete();
            bundleQ.delete();
            modelStallCnt = 0;
        end else begin
            if (pcQ.size() != 0 && id_stall && !IF_Flush && modelStallCnt < 16'hFFFF)
                modelStallCnt++;
            if (IF_Flush) begin
                pcQ.delete();
                bundleQ.delete();
            end else begin
                doPop  = (pcQ.size() != 0) && !id_stall;
                doPush = fetch_valid && (pcQ.size() < DEPTH);
                if (doPop) begin
                    void'(pcQ.pop_front());
                    void'(bundleQ.pop_front());
                end
                if (doPush) begin
                    pcQ.push_back(fetch_pc);
                    bundleQ.push_back(fetch_bundle);
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit v, input logic [PC_W-1:0] pc,
                                 input logic [47:0] b, input bit st, input bit fl);
        rst          = r;
        fetch_valid  = v;
        fetch_pc     = pc;
        fetch_bundle = b;
        id_stall     = st;
        IF_Flush     = fl;
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic checkOutput();
        logic [PC_W-1:0] ePc;
        logic [47:0]     eB;
        int              n;
        n   = pcQ.size();
        ePc = (n != 0) ? pcQ[0] : '0;
        eB  = (n != 0) ? bundleQ[0] : '0;
        checkVal("id_valid",    64'(id_valid),    64'(n != 0));
        checkVal("fetch_ready", 64'(fetch_ready), 64'(n < DEPTH));
        checkVal("count",       64'(count),       64'(n));
        checkVal("id_pc",       64'(id_pc),       64'(ePc));
        checkVal("id_instr",    64'(id_instr),    64'(eB[47:16]));
        checkVal("id_cinstr",   64'(id_cinstr),   64'(eB[15:0]));
        checkVal("opcode",      64'(opcode),      64'(eB[22:16]));
        checkVal("funct_3",     64'(funct_3),     64'(eB[30:28]));
        checkVal("opcode_c",    64'(opcode_c),    64'(eB[1:0]));
        checkVal("funct_3_c",   64'(funct_3_c),   64'(eB[15:13]));
`ifdef FETCH_STALL_CNT_EN
        checkVal("stall_cnt",   64'(stall_cnt),   64'(modelStallCnt));
`endif
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput();
            if (id_valid && id_pc == 32'h200)
                pc200Seen = 1'b1;
        end
    end

    initial begin
        checkCount    = 0;
        passCount     = 0;
        checkEn       = 1'b0;
        pc200Seen     = 1'b0;
        modelStallCnt = 0;

        applyStimulus(1, 0, '0, '0, 0, 0);
        applyStimulus(1, 0, '0, '0, 0, 0);
        checkEn = 1'b1;
        checkVal("reset_count",       64'(count),       64'd0);
        checkVal("reset_id_valid",    64'(id_valid),    64'd0);
        checkVal("reset_fetch_ready", 64'(fetch_ready), 64'd1);
        checkVal("reset_id_instr",    64'(id_instr),    64'd0);

        // Single push and field split.
        applyStimulus(0, 1, 32'h100, 48'h00A00093_4501, 1, 0);
        checkVal("push1_id_valid",  64'(id_valid),  64'd1);
        checkVal("push1_opcode",    64'(opcode),    64'h13);
        checkVal("push1_funct_3",   64'(funct_3),   64'd0);
        checkVal("push1_opcode_c",  64'(opcode_c),  64'd1);
        checkVal("push1_funct_3_c", 64'(funct_3_c), 64'd2);
        checkVal("push1_count",     64'(count),     64'd1);

        // Fill under stall, third bundle held off, then drain in order.
        applyStimulus(0, 1, 32'h104, 48'h11111111_2222, 1, 0);
        checkVal("full_fetch_ready", 64'(fetch_ready), 64'd0);
        applyStimulus(0, 1, 32'h108, 48'h33333333_4444, 1, 0);
        checkVal("held_count", 64'(count), 64'd2);
        checkVal("held_head",  64'(id_pc), 64'h100);
        applyStimulus(0, 1, 32'h108, 48'h33333333_4444, 0, 0);
        checkVal("drain1_head",  64'(id_pc), 64'h104);
        checkVal("drain1_count", 64'(count), 64'd1);
        applyStimulus(0, 1, 32'h108, 48'h33333333_4444, 0, 0);
        checkVal("drain2_head", 64'(id_pc), 64'h108);
        applyStimulus(0, 0, '0, '0, 0, 0);
        checkVal("drain3_count", 64'(count), 64'd0);

        // Full buffer with simultaneous push attempt and pop.
        applyStimulus(0, 1, 32'h110, 48'h0000A013_0001, 1, 0);
        applyStimulus(0, 1, 32'h114, 48'h0000B013_0002, 1, 0);
        applyStimulus(0, 1, 32'h118, 48'h0000C013_0003, 0, 0);
        checkVal("fullpop_count", 64'(count),       64'd1);
        checkVal("fullpop_ready", 64'(fetch_ready), 64'd1);
        checkVal("fullpop_head",  64'(id_pc),       64'h114);

        // Flush with a concurrent push.
        applyStimulus(0, 1, 32'h11C, 48'h0000D013_0004, 1, 0);
        applyStimulus(0, 1, 32'h200, 48'hDEADBEEF_CAFE, 0, 1);
        checkVal("flush_count",    64'(count),     64'd0);
        checkVal("flush_id_valid", 64'(id_valid),  64'd0);
        checkVal("flush_id_pc",    64'(id_pc),     64'd0);
        checkVal("flush_cinstr",   64'(id_cinstr), 64'd0);
        applyStimulus(0, 0, '0, '0, 0, 0);
        checkVal("flush_no_200", 64'(pc200Seen), 64'd0);

        // Reset mid-stream with a push pending.
        applyStimulus(0, 1, 32'h300, 48'h12345678_9ABC, 1, 0);
        applyStimulus(1, 1, 32'h304, 48'h87654321_0FED, 1, 0);
        checkVal("midrst_count", 64'(count),       64'd0);
        checkVal("midrst_valid", 64'(id_valid),    64'd0);
        checkVal("midrst_ready", 64'(fetch_ready), 64'd1);

`ifdef FETCH_STALL_CNT_EN
        applyStimulus(0, 1, 32'h400, 48'h00000013_0001, 1, 0);
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 0, '0, '0, 1, 0);
        checkVal("stall_cnt_5", 64'(stall_cnt), 64'd5);
        for (int i = 0; i < 65535; i++)
            applyStimulus(0, 0, '0, '0, 1, 0);
        checkVal("stall_cnt_sat", 64'(stall_cnt), 64'hFFFF);
        applyStimulus(0, 0, '0, '0, 1, 1);
        applyStimulus(1, 0, '0, '0, 0, 0);
        checkVal("stall_cnt_rst", 64'(stall_cnt), 64'd0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 99) < 65),
                          {$urandom_range(0, 32'hFFFF), 2'b00},
                          {$urandom, 16'($urandom)},
                          ($urandom_range(0, 99) < 40),
                          ($urandom_range(0, 99) < 4));
        end

        applyStimulus(0, 0, '0, '0, 0, 0);
        checkEn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
